// File: rtl/screen_fill.sv
`default_nettype none
// ============================================================================
// Module   : screen_fill
// Purpose  : Raster fill engine for the VGA write port, with solid and
//            background-copy modes. Define FILL_REGION_EN to add region ports.
// Revision : 1.0 - initial release
// ============================================================================
module screen_fill #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int XW      = 8,
    parameter int YW      = 8,
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               mode,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               lock,
`ifdef FILL_REGION_EN
    input  logic [XW-1:0]      x_start,
    input  logic [XW-1:0]      x_end,
    input  logic [YW-1:0]      y_start,
    input  logic [YW-1:0]      y_end,
`endif
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_q,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [XW-1:0]     X_MAX   = XW'(H_RES - 1);
    localparam logic [YW-1:0]     Y_MAX   = YW'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_mode;
    logic [COLOR_W-1:0]   r_fg;
    logic [COLOR_W-1:0]   r_bg;
    logic [XW-1:0]        r_xs;
    logic [XW-1:0]        r_xe;
    logic [YW-1:0]        r_ye;
    logic                 r_empty;
    logic [XW-1:0]        r_cx;
    logic [YW-1:0]        r_cy;
    logic [XW-1:0]        r_x1;
    logic [YW-1:0]        r_y1;
    logic                 r_valid1;

    logic [XW-1:0]        w_xs;
    logic [XW-1:0]        w_xe;
    logic [YW-1:0]        w_ys;
    logic [YW-1:0]        w_ye;
    logic                 w_empty;
    logic [ADDR_W-1:0]    w_start_addr;
    logic                 w_issue;
    logic                 w_last;

    always_comb begin
`ifdef FILL_REGION_EN
        w_xs = x_start;
        w_ys = y_start;
        w_xe = (x_end > X_MAX) ? X_MAX : x_end;
        w_ye = (y_end > Y_MAX) ? Y_MAX : y_end;
`else
        w_xs = '0;
        w_ys = '0;
        w_xe = X_MAX;
        w_ye = Y_MAX;
`endif
        w_empty      = (w_xs > w_xe) || (w_ys > w_ye);
        w_start_addr = ADDR_W'(w_ys) * H_RES_A + ADDR_W'(w_xs);
        w_issue      = (r_state == S_RUN) && lock && !r_empty;
        w_last       = (r_cx == r_xe) && (r_cy == r_ye);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_xs     <= '0;
            r_xe     <= '0;
            r_ye     <= '0;
            r_empty  <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_valid1 <= 1'b0;
            mem_addr <= '0;
            x        <= '0;
            y        <= '0;
            color    <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // The pipeline advances every cycle; lock only gates the issue.
            r_valid1 <= w_issue;
            if (w_issue) begin
                r_x1 <= r_cx;
                r_y1 <= r_cy;
            end
            x     <= r_x1;
            y     <= r_y1;
            plot  <= r_valid1;
            color <= (r_mode && mem_q) ? r_fg : r_bg;
            done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_fg     <= fg_color;
                        r_bg     <= bg_color;
                        r_xs     <= w_xs;
                        r_xe     <= w_xe;
                        r_ye     <= w_ye;
                        r_empty  <= w_empty;
                        r_cx     <= w_xs;
                        r_cy     <= w_ys;
                        mem_addr <= w_start_addr;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_empty) begin
                        r_state <= S_DRAIN;
                    end else if (lock) begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (r_cx == r_xe) begin
                            // Step back to the region's left edge on the next line.
                            r_cx     <= r_xs;
                            r_cy     <= r_cy + 1'b1;
                            mem_addr <= mem_addr + H_RES_A - ADDR_W'(r_xe - r_xs);
                        end else begin
                            r_cx     <= r_cx + 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_valid1) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
